// File: rtl/tx_core_pkg.sv
// tx_core_pkg: shared gain constant, saturation/magnitude helpers and peak FSM states for the TX lane datapath
package tx_core_pkg;
   localparam int GAIN_FRAC = 6;
   typedef enum logic {IDLE, RUN} peak_state_t;
   function automatic longint sat_sample(input longint v, input int w);
      longint hi, lo;
      hi = (longint'(1) <<< (w - 1)) - 1;
      lo = -(longint'(1) <<< (w - 1));
      return (v > hi) ? hi : (v < lo) ? lo : v;
   endfunction
   function automatic longint abs_clamp(input longint v, input int w);
      longint hi;
      hi = (longint'(1) <<< (w - 1)) - 1;
      return (v < 0) ? ((-v > hi) ? hi : -v) : v;
   endfunction
endpackage

// File: rtl/tx_gain_lane.sv
// tx_gain_lane: one lane's gain multiply, scaled arithmetic shift and saturation with its saturation flag
module tx_gain_lane
   import tx_core_pkg::*;
#(
   parameter int SAMPLE_W = 16,
   parameter int GAIN_W   = 8
) (
   input  logic                       clock,
   input  logic                       resetn,
   input  logic signed [SAMPLE_W-1:0] sample,
   input  logic [GAIN_W-1:0]          gain,
   input  logic [3:0]                 scale,
   output logic signed [SAMPLE_W-1:0] dac,
   output logic                       sat
);
   localparam int PROD_W = SAMPLE_W + GAIN_W + 1;
   logic signed [PROD_W-1:0] prod_q, shifted;
   logic [3:0] scale_q;
   longint pre, post;
   always_comb begin
      shifted = prod_q >>> (scale_q + 5'(GAIN_FRAC));
      pre = longint'(shifted);
      post = sat_sample(pre, SAMPLE_W);
   end
   always_ff @(posedge clock or negedge resetn)
      if (!resetn) begin
         prod_q  <= '0;
         scale_q <= '0;
         dac     <= '0;
         sat     <= 1'b0;
      end else begin
         prod_q  <= PROD_W'(sample) * PROD_W'($signed({1'b0, gain}));
         scale_q <= scale;
         dac     <= SAMPLE_W'(post);
         sat     <= post != pre;
      end
endmodule

// File: rtl/tx_lane_gain_monitor.sv
// tx_lane_gain_monitor: source mux, gain lanes and interval peak monitor; TX_SAT_COUNT_EN adds sat_count
module tx_lane_gain_monitor
   import tx_core_pkg::*;
#(
   parameter int NUM_LANES  = 8,
   parameter int SAMPLE_W   = 16,
   parameter int NUM_SRC    = 3,
   parameter int GAIN_W     = 8,
   parameter int INTERVAL_W = 16
) (
   input  logic                                  clock,
   input  logic                                  resetn,
   input  logic                                  tx_enable,
   input  logic [$clog2(NUM_SRC)-1:0]            src_sel,
   input  logic [NUM_SRC*NUM_LANES*SAMPLE_W-1:0] adc_data,
   input  logic [GAIN_W-1:0]                     gain,
   input  logic [3:0]                            scale_select,
   input  logic [INTERVAL_W-1:0]                 interval_len,
   output logic [NUM_LANES*SAMPLE_W-1:0]         dac_data,
   output logic [SAMPLE_W-1:0]                   interval_max,
   output logic                                  interval_valid
`ifdef TX_SAT_COUNT_EN
   ,
   output logic [15:0]                           sat_count
`endif
);
   localparam int BUS_W = NUM_LANES * SAMPLE_W;
   logic [BUS_W-1:0] sel_bus, s1_data;
   logic [GAIN_W-1:0] s1_gain;
   logic [3:0] s1_scale;
   logic [NUM_LANES-1:0] lane_sat;
   logic [SAMPLE_W-1:0] lane_max, mag;
   always_comb begin
      sel_bus = '0;
      for (int s = 0; s < NUM_SRC; s++)
         if (int'(src_sel) == s) sel_bus = adc_data[s*BUS_W +: BUS_W];
   end
   // gain and shift travel with the data so a config change only affects later samples
   always_ff @(posedge clock or negedge resetn)
      if (!resetn) begin
         s1_data  <= '0;
         s1_gain  <= '0;
         s1_scale <= '0;
      end else begin
         s1_data  <= tx_enable ? sel_bus : '0;
         s1_gain  <= gain;
         s1_scale <= scale_select;
      end
   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      tx_gain_lane #(.SAMPLE_W(SAMPLE_W), .GAIN_W(GAIN_W)) u_lane (
         .clock  (clock),
         .resetn (resetn),
         .sample (s1_data[l*SAMPLE_W +: SAMPLE_W]),
         .gain   (s1_gain),
         .scale  (s1_scale),
         .dac    (dac_data[l*SAMPLE_W +: SAMPLE_W]),
         .sat    (lane_sat[l])
      );
   end
   always_comb begin
      lane_max = '0;
      mag = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         mag = SAMPLE_W'(abs_clamp(longint'($signed(dac_data[i*SAMPLE_W +: SAMPLE_W])), SAMPLE_W));
         lane_max = (mag > lane_max) ? mag : lane_max;
      end
   end
   peak_state_t state, state_d;
   logic [INTERVAL_W-1:0] cnt, cnt_d, len_q, len_d;
   logic [SAMPLE_W-1:0] peak, peak_d, peak_next, max_d;
   logic valid_d, boundary;
   always_comb begin
      peak_next = (lane_max > peak) ? lane_max : peak;
      boundary = (state == RUN) && (cnt == len_q - INTERVAL_W'(1));
      state_d = state;
      cnt_d = cnt + INTERVAL_W'(1);
      len_d = len_q;
      peak_d = peak_next;
      max_d = interval_max;
      valid_d = 1'b0;
      if (state == IDLE) begin
         cnt_d = '0;
         peak_d = '0;
         len_d = (interval_len != '0) ? interval_len : len_q;
         state_d = (interval_len != '0) ? RUN : IDLE;
      end else if (boundary) begin
         max_d = peak_next;
         valid_d = 1'b1;
         cnt_d = '0;
         peak_d = '0;
         len_d = interval_len;
         state_d = (interval_len == '0) ? IDLE : RUN;
      end
   end
   always_ff @(posedge clock or negedge resetn)
      if (!resetn) begin
         state          <= IDLE;
         cnt            <= '0;
         len_q          <= '0;
         peak           <= '0;
         interval_max   <= '0;
         interval_valid <= 1'b0;
      end else begin
         state          <= state_d;
         cnt            <= cnt_d;
         len_q          <= len_d;
         peak           <= peak_d;
         interval_max   <= max_d;
         interval_valid <= valid_d;
      end
`ifdef TX_SAT_COUNT_EN
   logic [16:0] sat_sum;
   assign sat_sum = {1'b0, sat_count} + 17'($countones(lane_sat));
   always_ff @(posedge clock or negedge resetn)
      if (!resetn) sat_count <= '0;
      else sat_count <= boundary ? '0 : sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
`else
   logic unused_sat;
   assign unused_sat = ^{lane_sat, boundary};
`endif
endmodule

// File: tb/tb_tx_lane_gain_monitor.sv
// tb_tx_lane_gain_monitor: randomized scoreboard bench against a behavioural model of the TX lane datapath
module tb_tx_lane_gain_monitor;
   localparam int NL = 8, SW = 16, NS = 3, GW = 8, IW = 16, BW = NL * SW;
   logic clock = 1'b0, resetn = 1'b0, tx_enable = 1'b0;
   logic [1:0] src_sel = '0;
   logic [NS*BW-1:0] adc_data = '0;
   logic [GW-1:0] gain = '0;
   logic [3:0] scale_select = '0;
   logic [IW-1:0] interval_len = '0;
   logic [BW-1:0] dac_data;
   logic [SW-1:0] interval_max;
   logic interval_valid;
`ifdef TX_SAT_COUNT_EN
   logic [15:0] sat_count;
`endif
   int total = 0, bad = 0;
   always #5 clock = ~clock;

   tx_lane_gain_monitor dut (
      .clock          (clock),
      .resetn         (resetn),
      .tx_enable      (tx_enable),
      .src_sel        (src_sel),
      .adc_data       (adc_data),
      .gain           (gain),
      .scale_select   (scale_select),
      .interval_len   (interval_len),
      .dac_data       (dac_data),
      .interval_max   (interval_max),
      .interval_valid (interval_valid)
`ifdef TX_SAT_COUNT_EN
      ,
      .sat_count      (sat_count)
`endif
   );

   typedef struct { logic [BW-1:0] dac; int nsat; } stage_t;
   typedef struct { logic [BW-1:0] dac; int sc; int imax; } exp_t;
   stage_t pipe[$];
   exp_t q_out[$];
   int q_int[$];
   stage_t cur, zero_s;
   int wlen, wpos, wpeak, last_max, sc, lm;
   bit bnd;

   task automatic chk(string n, longint act, longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", n, act, exp);
      end
   endtask

   // Real-number view of the datapath: floor(x*g / 2^(6+sh)) clamped to 16-bit range
   function automatic stage_t ref_stage(logic en, int sel, int g, int sh, logic [NS*BW-1:0] adc);
      stage_t r;
      longint x, v, d, q;
      r.nsat = 0;
      r.dac = '0;
      for (int l = 0; l < NL; l++) begin
         x = (en && sel < NS) ? longint'($signed(adc[(sel*NL+l)*SW +: SW])) : 0;
         v = x * g;
         d = longint'(1) << (6 + sh);
         q = v / d;
         if (v % d != 0 && v < 0) q = q - 1;
         if (q > 32767) begin q = 32767; r.nsat++; end
         else if (q < -32768) begin q = -32768; r.nsat++; end
         r.dac[l*SW +: SW] = q[SW-1:0];
      end
      return r;
   endfunction

   function automatic int peak_of(logic [BW-1:0] d);
      int m, a;
      logic signed [SW-1:0] s;
      m = 0;
      for (int l = 0; l < NL; l++) begin
         s = d[l*SW +: SW];
         a = (s < 0) ? -int'(s) : int'(s);
         if (a > 32767) a = 32767;
         if (a > m) m = a;
      end
      return m;
   endfunction

   always @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         zero_s = '{dac: '0, nsat: 0};
         pipe.delete();
         q_out.delete();
         q_int.delete();
         pipe.push_back(zero_s);
         pipe.push_back(zero_s);
         cur = zero_s;
         wlen = 0; wpos = 0; wpeak = 0; last_max = 0; sc = 0;
      end else begin
         lm = peak_of(cur.dac);
         bnd = 1'b0;
         if (wlen == 0) begin
            if (interval_len != 0) begin wlen = int'(interval_len); wpos = 0; wpeak = 0; end
         end else begin
            wpeak = (lm > wpeak) ? lm : wpeak;
            wpos++;
            if (wpos == wlen) begin
               last_max = wpeak;
               q_int.push_back(wpeak);
               bnd = 1'b1;
               wlen = int'(interval_len);
               wpos = 0;
               wpeak = 0;
            end
         end
         sc = bnd ? 0 : ((sc + cur.nsat > 65535) ? 65535 : sc + cur.nsat);
         pipe.push_back(ref_stage(tx_enable, int'(src_sel), int'(gain), int'(scale_select), adc_data));
         cur = pipe.pop_front();
         q_out.push_back('{dac: cur.dac, sc: sc, imax: last_max});
      end
   end

   exp_t e;
   int pend;
   always @(negedge clock) if (resetn) begin
      if (q_out.size() > 0) begin
         e = q_out.pop_front();
         total++;
         if (dac_data !== e.dac) begin
            bad++;
            $display("FAIL dac got=%h want=%h", dac_data, e.dac);
         end
         chk("interval_max_hold", longint'(interval_max), e.imax);
`ifdef TX_SAT_COUNT_EN
         chk("sat_count", longint'(sat_count), e.sc);
`endif
      end
      if (interval_valid || q_int.size() > 0) begin
         if (!interval_valid || q_int.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pulse valid=%0d pending=%0d", interval_valid, q_int.size());
            if (q_int.size() > 0) void'(q_int.pop_front());
         end else begin
            pend = q_int.pop_front();
            chk("interval_max_pulse", longint'(interval_max), pend);
         end
      end
   end

   task automatic rnd_adc();
      for (int w = 0; w < NS*BW/32; w++) adc_data[w*32 +: 32] = $urandom;
   endtask
   task automatic fill(int s, int v);
      for (int l = 0; l < NL; l++) adc_data[(s*NL+l)*SW +: SW] = SW'(v);
   endtask
   task automatic run(int n);
      repeat (n) @(negedge clock);
   endtask
   function automatic longint lane(int l);
      return longint'($signed(dac_data[l*SW +: SW]));
   endfunction

   initial begin
      run(2);
      chk("rst_dac", longint'(|dac_data), 0);
      chk("rst_imax", longint'(interval_max), 0);
      chk("rst_valid", longint'(interval_valid), 0);
      #2 resetn = 1'b1;
      tx_enable = 1'b1; gain = 8'd64; scale_select = 4'd0; src_sel = 2'd1;
      for (int c = 0; c < 8; c++) begin
         rnd_adc();
         adc_data[(1*NL+3)*SW +: SW] = 16'h1234;
         run(1);
      end
      chk("unity_lane3", lane(3), 'h1234);
      gain = 8'd255; src_sel = 2'd0;
      for (int c = 0; c < 6; c++) begin
         rnd_adc();
         for (int l = 0; l < NL; l++) adc_data[l*SW +: SW] = ($urandom_range(0, 1) != 0) ? SW'(20000) : SW'(-20000);
         run(1);
      end
      fill(0, 20000); run(3);
      chk("sat_pos", lane(0), 32767);
      fill(0, -20000); run(3);
      chk("sat_neg", lane(5), -32768);
      gain = 8'd64; scale_select = 4'd2;
      fill(0, -5); run(3);
      chk("shift_neg", lane(1), -2);
      fill(0, 7); run(3);
      chk("shift_pos", lane(2), 1);
      for (int c = 0; c < 6; c++) begin
         for (int l = 0; l < NL; l++) adc_data[l*SW +: SW] = ($urandom_range(0, 1) != 0) ? SW'(7) : SW'(-5);
         run(1);
      end
      scale_select = 4'd0; fill(0, 100); interval_len = IW'(10);
      run(5);
      adc_data[2*SW +: SW] = 16'h8000;
      run(1);
      fill(0, 100);
      run(40);
      chk("quiet_window", longint'(interval_max), 100);
      run(3);
      interval_len = IW'(4);
      run(25);
      interval_len = '0;
      run(20);
      chk("len0_no_pulse", longint'(interval_valid), 0);
      for (int c = 0; c < 1500; c++) begin
         rnd_adc();
         if ($urandom_range(0, 40) == 0) begin
            gain = GW'($urandom);
            scale_select = 4'($urandom_range(0, 15));
            src_sel = 2'($urandom_range(0, 3));
            tx_enable = $urandom_range(0, 9) != 0;
         end
         if ($urandom_range(0, 60) == 0)
            interval_len = ($urandom_range(0, 3) == 0) ? '0 : IW'($urandom_range(1, 20));
         run(1);
      end
      gain = 8'd255; scale_select = 4'd0; tx_enable = 1'b1; src_sel = 2'd0;
      fill(0, 20000); interval_len = IW'(7);
      run(13);
      #2 resetn = 1'b0;
      #1;
      chk("mid_rst_dac", longint'(|dac_data), 0);
      chk("mid_rst_imax", longint'(interval_max), 0);
      chk("mid_rst_valid", longint'(interval_valid), 0);
`ifdef TX_SAT_COUNT_EN
      chk("mid_rst_sat", longint'(sat_count), 0);
`endif
      @(negedge clock);
      #2 resetn = 1'b1;
      run(30);
      interval_len = '0;
      run(25);
      chk("pulses_drained", longint'(q_int.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end
endmodule
